multu_hilo: RTL
===============

# multu_hilo

Sequential unsigned multiplier with the architectural Hi/Lo register pair, sitting directly upstream of the ALU result mux. It executes the MIPS `MULTU` funct with a 32-iteration shift-add algorithm and drives `HiOut`/`LoOut`, which the result mux returns for `MFHI`/`MFLO`. Hi/Lo hold their value until the next completed multiply or reset.

## Interface
- `WIDTH`, 32, operand width; Hi and Lo are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `dataA`  in  WIDTH  multiplicand (rs).
- `dataB`  in  WIDTH  multiplier (rt).
- `Signal`  in  6  funct code; only `MULTU` = 6'b011001 starts an operation.
- `start`  in  1  request strobe, qualified by `Signal`.
- `busy`  out  1  high while a multiply is in progress.
- `done`  out  1  one-cycle pulse when Hi/Lo have just been updated.
- `HiOut`  out  WIDTH  upper half of the last completed product.
- `LoOut`  out  WIDTH  lower half of the last completed product.

## Operation
- The block has two states, IDLE and RUN. It leaves reset in IDLE.
- Acceptance: at a clock edge where the state is IDLE, `start`=1 and `Signal`==`MULTU`, the block:
  - latches `dataA` into the multiplicand register;
  - loads the accumulator with {WIDTH'b0, `dataB`};
  - clears the iteration counter;
  - enters RUN.
- Each RUN edge performs one iteration. If `acc[0]`=1, the multiplicand is added to `acc[2W-1:W]` with a (W+1)-bit sum. The {carry, acc} value is then shifted right by 1, and the counter increments.
- The counter is $clog2(WIDTH) bits wide and wraps. The last iteration is the one where counter==WIDTH-1. That edge writes `HiOut`=`acc_next[2W-1:W]` and `LoOut`=`acc_next[W-1:0]`, sets `done`=1 and returns the state to IDLE.
- The result is the exact unsigned 2W-bit product. There is no overflow or exception.
- `start` is ignored while in RUN. The operands in flight are not affected.
- `start` with any `Signal` other than `MULTU` is ignored in every state. This includes `MFHI`/`MFLO`, which only read outputs.
- `HiOut`/`LoOut` do not change during RUN. They keep the previous product until the final edge.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `HiOut`=0, `LoOut`=0, accumulator=0, counter=0.
- Let E0 be the acceptance edge.
  - `busy` is high from E0 through E(WIDTH) exclusive, i.e. exactly WIDTH cycles.
  - `HiOut`/`LoOut` update at edge E(WIDTH), which is 32 edges after acceptance for the default width.
  - `done` is high for exactly the cycle following E(WIDTH). `busy` is 0 in that cycle.
- Back-to-back: the state is IDLE in the `done` cycle, so a new `start` is accepted at E(WIDTH+1). `HiOut`/`LoOut` hold the first product until E(2·WIDTH+1).
- Reset during RUN: the operation is aborted. All registers, including `HiOut`/`LoOut`, return to 0 at that edge and no `done` pulse is issued.
- `reset` and `start` at the same edge: reset wins and the start is not accepted.
- `busy` and `done` are registered outputs, not combinational from `start`.

## Structure
- Shared package `alu_pkg`:
  - funct constants `MULTU`, `MFHI`, `MFLO`, also used by the result mux;
  - `WIDTH` default;
  - state enum {IDLE, RUN}.
- One sub-module is natural: `hilo_reg`, a Hi/Lo register pair with synchronous reset and a single write-enable. It is driven by the final-iteration strobe.
- The control FSM, counter and shift-add datapath stay in `multu_hilo`.

## Test plan
- Reset, then `dataA`=3, `dataB`=5, `MULTU` start → `busy` high for 32 cycles, `done` pulses once, `HiOut`=0x00000000, `LoOut`=0x0000000F.
- `dataA`=`dataB`=0xFFFFFFFF → `HiOut`=0xFFFFFFFE, `LoOut`=0x00000001. This covers the carry out of the adder on every iteration.
- First multiply 0x80000000×2. During its busy window, pulse `start` with 7×7 → result `HiOut`=0x00000001, `LoOut`=0x00000000, and no second `done`.
- `start` with `Signal`=`MFHI`, then with `ADD` (6'b100000) → no `busy`, and `HiOut`/`LoOut` keep their prior values.
- `reset` asserted 10 cycles into 0x12345678×0x9ABCDEF0 → next cycle: `busy`=0, `done`=0, `HiOut`=`LoOut`=0. A following 2×3 gives `LoOut`=6.
- Back-to-back: start 0x10000×0x10000, then start 0xFFFF×0x2 in the `done` cycle → first result `HiOut`=1, `LoOut`=0. It is held until the second result appears at E65: `HiOut`=0, `LoOut`=0x1FFFE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: funct codes used by the multiplier and the result mux,
// the default datapath width and the multiplier control states.
package alu_pkg;

   localparam int MULT_WIDTH = 32;

   localparam logic [5:0] MULTU = 6'b011001;
   localparam logic [5:0] MFHI  = 6'b010000;
   localparam logic [5:0] MFLO  = 6'b010010;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/hilo_reg.sv
// Architectural Hi/Lo register pair: a single write-enable loads both halves,
// and they hold their value otherwise.
module hilo_reg #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_we,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (i_we) begin
         r_hi <= i_hi;
         r_lo <= i_lo;
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

// File: rtl/multu_hilo.sv
// Sequential unsigned shift-add multiplier (MIPS MULTU). One iteration per clock;
// the final iteration writes the product into the Hi/Lo pair and pulses done.
module multu_hilo
   import alu_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [CW-1:0]      r_cnt;
   logic               r_done;

   logic               w_accept;
   logic               w_last;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_acc_next;

   assign w_accept = (r_state == IDLE) && start && (Signal == MULTU);
   assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);

   // Adder keeps its carry so the shift brings it into the top bit of the accumulator.
   assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
   assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = RUN;
         RUN:     if (w_last)   w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mcand <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_accept) begin
            r_mcand <= dataA;
            r_acc   <= {{WIDTH{1'b0}}, dataB};
            r_cnt   <= '0;
         end else if (r_state == RUN) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   hilo_reg #(
      .WIDTH(WIDTH)
   ) u_hilo (
      .i_clk  (clk),
      .i_reset(reset),
      .i_we   (w_last),
      .i_hi   (w_acc_next[2*WIDTH-1:WIDTH]),
      .i_lo   (w_acc_next[WIDTH-1:0]),
      .o_hi   (HiOut),
      .o_lo   (LoOut)
   );

   assign busy = (r_state == RUN);
   assign done = r_done;

endmodule
